mean_compens_v3: RTL and testbench

- Multi-channel DC-offset (mean) remover for signed ADC sample streams; successor to mean_compens_v2.
- Adds four things v2 lacks: N_CH parallel channels, a sample-enable strobe, gear-shifted fast acquisition (time constant steps from 2^TAU_MIN up to 2^TAU_MAX), and freeze/clear control with mean readback.
- Sits directly after lim_qnt, in front of the correlator/DSP chain.

---
 rtl/mean_compens_v3.sv | 157 +++++++++++++++
 tb/tb_mean_compens_v3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mean_compens_v3.sv
// mean_compens_v3: multi-channel DC-offset remover for signed ADC streams.
// Each channel tracks its mean in a fixed-point accumulator. The time constant
// starts short for fast acquisition and is stepped up ("geared") to a long
// tracking value. A single FSM and set of controls is shared by all channels.
module mean_compens_v3 #(
  parameter int N_CH         = 2,
  parameter int WIDTH        = 14,
  parameter int TAU_MIN      = 6,
  parameter int TAU_MAX      = 15,
  parameter int ACQ_LEN_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   freeze,
  input  logic                   clear,
  input  logic [N_CH*WIDTH-1:0]  data_in,
  output logic [N_CH*WIDTH-1:0]  data_out,
  output logic [N_CH*WIDTH-1:0]  mean_out,
  output logic                   valid,
  output logic                   locked
);

  // Accumulator carries TAU_MAX fractional bits; two guard bits absorb the update sum.
  localparam int AW = WIDTH + TAU_MAX;
  localparam int SW = AW + 2;
  localparam int TW = $clog2(TAU_MAX + 1);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tau_q, tau_d;
  logic [ACQ_LEN_LOG2-1:0] cnt_q, cnt_d;

  logic signed [AW-1:0]    acc_q [N_CH];
  logic signed [AW-1:0]    acc_d [N_CH];
  logic signed [WIDTH-1:0] x_c   [N_CH];
  logic signed [WIDTH-1:0] m_c   [N_CH];
  logic signed [WIDTH:0]   d_c   [N_CH];
  logic signed [WIDTH-1:0] y_c   [N_CH];
  logic signed [SW-1:0]    step_c[N_CH];
  logic signed [SW-1:0]    sum_c [N_CH];

  logic [N_CH*WIDTH-1:0]   data_q, data_d;
  logic [N_CH*WIDTH-1:0]   mean_q, mean_d;
  logic                    valid_q, valid_d;
  logic                    upd;
  logic [TW-1:0]           shamt;

  // Clamp the (WIDTH+1)-bit difference into the WIDTH-bit output range.
  function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1])
      sat_out = v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat_out = v[WIDTH-1:0];
  endfunction

  // Clamp the guarded sum back to AW bits so the mean's integer part never wraps.
  function automatic logic signed [AW-1:0] sat_acc(input logic signed [SW-1:0] v);
    if ((v[SW-1:AW-1] == '0) || (v[SW-1:AW-1] == '1))
      sat_acc = v[AW-1:0];
    else
      sat_acc = v[SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  endfunction

  // Gear FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ACQ;
      tau_q   <= TW'(TAU_MIN);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tau_q   <= tau_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gear FSM next state: count updating samples, step tau every 2^ACQ_LEN_LOG2.
  always_comb begin
    state_d = state_q;
    tau_d   = tau_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ACQ;
      tau_d   = TW'(TAU_MIN);
      cnt_d   = '0;
    end else if (en && !freeze && (state_q == ACQ)) begin
      if (cnt_q == '1) begin
        cnt_d = '0;
        tau_d = tau_q + TW'(1);
        if (tau_d == TW'(TAU_MAX)) state_d = TRACK;
      end else begin
        cnt_d = cnt_q + ACQ_LEN_LOG2'(1);
      end
    end
  end

  // Gear FSM outputs.
  always_comb begin
    locked = (state_q == TRACK);
  end

  // Per-channel arithmetic: mean, difference, saturated output, accumulator update.
  always_comb begin
    upd   = en & ~freeze & ~clear;
    shamt = TW'(TAU_MAX) - tau_q;
    for (int c = 0; c < N_CH; c++) begin
      x_c[c]    = data_in[c*WIDTH +: WIDTH];
      m_c[c]    = acc_q[c][AW-1:TAU_MAX];
      d_c[c]    = {x_c[c][WIDTH-1], x_c[c]} - {m_c[c][WIDTH-1], m_c[c]};
      y_c[c]    = sat_out(d_c[c]);
      step_c[c] = {{(SW-WIDTH-1){d_c[c][WIDTH]}}, d_c[c]} <<< shamt;
      sum_c[c]  = {{(SW-AW){acc_q[c][AW-1]}}, acc_q[c]} + step_c[c];
      acc_d[c]  = acc_q[c];
      if (clear)    acc_d[c] = '0;
      else if (upd) acc_d[c] = sat_acc(sum_c[c]);
    end
  end

  // Output register next values: clear zeroes, en captures, otherwise hold.
  always_comb begin
    data_d  = data_q;
    mean_d  = mean_q;
    valid_d = 1'b0;
    if (clear) begin
      data_d = '0;
      mean_d = '0;
    end else if (en) begin
      valid_d = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        data_d[c*WIDTH +: WIDTH] = y_c[c];
        mean_d[c*WIDTH +: WIDTH] = m_c[c];
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
      data_q  <= '0;
      mean_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) acc_q[c] <= acc_d[c];
      data_q  <= data_d;
      mean_q  <= mean_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign mean_out = mean_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_mean_compens_v3.sv
// Directed bench for mean_compens_v3 with default parameters (2 channels, 14 bit).
module tb_mean_compens_v3;

  localparam int N_CH  = 2;
  localparam int WIDTH = 14;

  logic                  clk;
  logic                  resetn;
  logic                  en;
  logic                  freeze;
  logic                  clear;
  logic [N_CH*WIDTH-1:0] data_in;
  logic [N_CH*WIDTH-1:0] data_out;
  logic [N_CH*WIDTH-1:0] mean_out;
  logic                  valid;
  logic                  locked;

  int n_tests;
  int n_fail;

  mean_compens_v3 dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .freeze   (freeze),
    .clear    (clear),
    .data_in  (data_in),
    .data_out (data_out),
    .mean_out (mean_out),
    .valid    (valid),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed against expected with an absolute tolerance.
  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_tests++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int dout(input int c);
    logic signed [WIDTH-1:0] v;
    v = data_out[c*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  function automatic int mout(input int c);
    logic signed [WIDTH-1:0] v;
    v = mean_out[c*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  // Present one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic cyc(input int x0, input int x1, input logic e, input logic f, input logic c);
    logic [WIDTH-1:0] a0, a1;
    a0 = x0[WIDTH-1:0];
    a1 = x1[WIDTH-1:0];
    data_in = {a1, a0};
    en      = e;
    freeze  = f;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    en      = 1'b0;
    freeze  = 1'b0;
    clear   = 1'b0;
    data_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", int'(data_out), 0, 0);
    chk("rst_mean", int'(mean_out), 0, 0);
    chk("rst_valid", int'(valid), 0, 0);
    chk("rst_locked", int'(locked), 0, 0);
    resetn = 1'b1;

    // First sample: mean still zero, acc0=512000, acc1=-256000
    cyc(1000, -500, 1, 0, 0);
    chk("s1_d0", dout(0), 1000, 0);
    chk("s1_d1", dout(1), -500, 0);
    chk("s1_m0", mout(0), 0, 0);
    chk("s1_valid", int'(valid), 1, 0);

    // Frozen sample: m0=15, m1=-8, acc unchanged, not counted
    cyc(1200, -500, 1, 1, 0);
    chk("frz_d0", dout(0), 1185, 0);
    chk("frz_d1", dout(1), -492, 0);
    chk("frz_m0", mout(0), 15, 0);
    chk("frz_m1", mout(1), -8, 0);

    // Idle cycle: valid drops, outputs hold
    cyc(0, 0, 0, 0, 0);
    chk("idle_valid", int'(valid), 0, 0);
    chk("idle_d0", dout(0), 1185, 0);
    chk("idle_m1", mout(1), -8, 0);

    // Updates resume from the held accumulator
    cyc(1000, -500, 1, 0, 0);
    chk("s3_d0", dout(0), 985, 0);
    chk("s3_m0", mout(0), 15, 0);
    chk("s3_d1", dout(1), -492, 0);
    cyc(1000, -500, 1, 0, 0);
    chk("s4_d0", dout(0), 969, 0);
    chk("s4_m0", mout(0), 31, 0);
    chk("s4_d1", dout(1), -484, 0);
    chk("s4_m1", mout(1), -16, 0);

    // Three samples counted so far; lock at exactly 2304
    for (int i = 0; i < 2300; i++) cyc(1000, -500, 1, 0, 0);
    chk("lock_pre", int'(locked), 0, 0);
    cyc(1000, -500, 1, 0, 0);
    chk("lock_at", int'(locked), 1, 0);
    chk("dc_m0", mout(0), 1000, 1);
    chk("dc_m1", mout(1), -500, 1);
    chk("dc_d0", dout(0), 0, 1);
    chk("dc_d1", dout(1), 0, 1);

    // Frozen step and saturation against the locked means
    cyc(1200, -500, 1, 1, 0);
    chk("frz_step_d0", dout(0), 200, 1);
    chk("frz_step_m0", mout(0), 1000, 1);
    cyc(-8192, 8191, 1, 1, 0);
    chk("sat_neg", dout(0), -8192, 0);
    chk("sat_pos", dout(1), 8191, 0);
    chk("sat_lock", int'(locked), 1, 0);

    // Clear from TRACK
    cyc(0, 0, 1, 0, 1);
    chk("clr1_data", int'(data_out), 0, 0);
    chk("clr1_mean", int'(mean_out), 0, 0);
    chk("clr1_valid", int'(valid), 0, 0);
    chk("clr1_locked", int'(locked), 0, 0);

    // Long full-scale input from a cleared state
    cyc(-8192, 8191, 1, 0, 0);
    chk("fs_first0", dout(0), -8192, 0);
    chk("fs_first1", dout(1), 8191, 0);
    for (int i = 0; i < 1099; i++) cyc(-8192, 8191, 1, 0, 0);
    chk("fs_m0", mout(0), -8192, 16);
    chk("fs_m1", mout(1), 8191, 16);
    chk("fs_lock", int'(locked), 0, 0);

    // Clear mid-ACQ (tau=10) with a sample presented: discarded
    cyc(300, -2000, 1, 0, 1);
    chk("clr2_data", int'(data_out), 0, 0);
    chk("clr2_mean", int'(mean_out), 0, 0);
    chk("clr2_valid", int'(valid), 0, 0);
    chk("clr2_locked", int'(locked), 0, 0);

    // Reacquire with en on alternate cycles
    for (int p = 0; p < 2303; p++) begin
      cyc(300, -2000, 1, 0, 0);
      if (p == 0) chk("alt_valid_hi", int'(valid), 1, 0);
      cyc(300, -2000, 0, 0, 0);
      if (p == 0) chk("alt_valid_lo", int'(valid), 0, 0);
    end
    chk("alt_lock_pre", int'(locked), 0, 0);
    cyc(300, -2000, 1, 0, 0);
    chk("alt_lock_at", int'(locked), 1, 0);
    chk("alt_m0", mout(0), 300, 1);
    chk("alt_m1", mout(1), -2000, 1);

    // Asynchronous reset mid-TRACK, between clock edges
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_data", int'(data_out), 0, 0);
    chk("arst_mean", int'(mean_out), 0, 0);
    chk("arst_valid", int'(valid), 0, 0);
    chk("arst_locked", int'(locked), 0, 0);
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
